// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Brief    : Memory-mapped 8N1 UART transmitter with a small byte FIFO.
//            Registers sit in a 16-byte window on the CPU data bus; bus data
//            arrives and leaves in byte-reversed lane order.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH       = 4,
    parameter logic [31:0] DEFAULT_DIV = 32'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memAddress,
    input  logic [31:0] memWriteData,
    input  logic [3:0]  byteMask,
    input  logic        memWrite,
    output logic [31:0] readData,
    output logic        txd
);

    localparam int            c_AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            c_CW         = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        w_hit;
    logic [1:0]  w_off;
    logic [31:0] w_wval;
    logic        w_wr_tx;
    logic        w_wr_stat;
    logic        w_wr_div;
    logic        w_unused_addr;

    assign w_hit   = (memAddress[31:4] == BASE_ADDR[31:4]);
    assign w_off   = memAddress[3:2];
    // Byte-swapped write data: the register value the core meant to store.
    assign w_wval  = {memWriteData[7:0], memWriteData[15:8],
                      memWriteData[23:16], memWriteData[31:24]};
    assign w_wr_tx   = memWrite && w_hit && (w_off == 2'd0) && byteMask[3];
    assign w_wr_stat = memWrite && w_hit && (w_off == 2'd1) && (byteMask == 4'b1111);
    assign w_wr_div  = memWrite && w_hit && (w_off == 2'd2) && (byteMask == 4'b1111);
    assign w_unused_addr = &{1'b0, memAddress[1:0]};

    // ------------------------------------------------------------------
    // FIFO and control registers
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic [31:0]     r_div;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;

    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_empty   = (r_count == '0);
    // Fullness is judged before the edge, so a same-cycle pop cannot save a push.
    assign w_push    = w_wr_tx && !w_full;
    assign w_ovf_set = w_wr_tx && w_full;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= memWriteData[31:24];
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Overflow flag (a new overflow beats a same-cycle clear) and baud divisor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_div <= DEFAULT_DIV;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && w_wval[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_div) begin
                r_div <= (w_wval == 32'd0) ? 32'd1 : w_wval;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_bitcnt;
    logic [31:0] w_bitcnt_nxt;
    logic [2:0]  r_bitidx;
    logic [2:0]  w_bitidx_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [31:0] r_frame_div;
    logic [31:0] w_frame_div_nxt;
    logic        r_txd;
    logic        w_txd_nxt;
    logic        w_bit_end;

    assign w_bit_end = (r_bitcnt == (r_frame_div - 32'd1));

    // State register; txd is registered from the next state so it never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_bitidx    <= '0;
            r_shift     <= '0;
            r_frame_div <= DEFAULT_DIV;
            r_txd       <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_bitidx    <= w_bitidx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_div <= w_frame_div_nxt;
            r_txd       <= w_txd_nxt;
        end
    end

    // Next-state logic: bit timing, LSB-first shifting and FIFO pop.
    always_comb begin
        w_state_nxt     = r_state;
        w_bitcnt_nxt    = r_bitcnt;
        w_bitidx_nxt    = r_bitidx;
        w_shift_nxt     = r_shift;
        w_frame_div_nxt = r_frame_div;
        w_pop           = 1'b0;
        w_txd_nxt       = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_shift_nxt     = r_mem[r_rptr];
                    w_frame_div_nxt = r_div;
                    w_bitcnt_nxt    = '0;
                    w_state_nxt     = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bitcnt_nxt = '0;
                    w_bitidx_nxt = '0;
                    w_state_nxt  = S_DATA;
                end else begin
                    w_bitcnt_nxt = r_bitcnt + 32'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_bitcnt_nxt = '0;
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_bitidx_nxt = r_bitidx + 3'd1;
                    if (r_bitidx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_bitcnt_nxt = r_bitcnt + 32'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_bitcnt_nxt = r_bitcnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_state_nxt == S_START) begin
            w_txd_nxt = 1'b0;
        end else if (w_state_nxt == S_DATA) begin
            w_txd_nxt = w_shift_nxt[0];
        end
    end

    assign txd = r_txd;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_rd_val;

    // Register read value; returned on the bus in byte-reversed order.
    always_comb begin
        w_rd_val = '0;
        if (w_hit) begin
            case (w_off)
                2'd1:    w_rd_val = {23'd0, 5'(r_count), r_ovf,
                                     (r_state != S_IDLE), w_empty, w_full};
                2'd2:    w_rd_val = r_div;
                default: w_rd_val = '0;
            endcase
        end
    end

    assign readData = {w_rd_val[7:0], w_rd_val[15:8],
                       w_rd_val[23:16], w_rd_val[31:24]};

endmodule
`default_nettype wire

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU data bus, downstream of the CPU core.
- Consumes the core's memAddress, memWriteData, byteMask and memWrite outputs.
- Returns register contents on readData, which the bus mux feeds into the core's read-data input.
- Buffers stored bytes in a small FIFO and serialises them as 8N1 frames on txd.

Parameters:
- BASE_ADDR, 32'h0001_0000: 16-byte aligned base address of the register window.
- DEPTH, 4: FIFO entries; power of two, 2 to 16.
- DEFAULT_DIV, 868: reset value of the baud divisor, in clock cycles per bit.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- memAddress  input  32  bus byte address
- memWriteData  input  32  bus write data, byte-reversed lane order as driven by the core
- byteMask  input  4  lane enables; bit3 selects lane [31:24]
- memWrite  input  1  write strobe, asserted for exactly one cycle per store
- readData  output  32  combinational register read data, byte-reversed
- txd  output  1  serial output, idles high

Behaviour:
- Decode and lane order
  - hit = (memAddress[31:4] == BASE_ADDR[31:4]); offset = memAddress[3:2].
  - Register value V is presented as readData = {V[7:0], V[15:8], V[23:16], V[31:24]}.
  - readData = 0 when hit = 0 or offset = 3. Reads are combinational and have no side effects.
- Offset 0, TXDATA (write only; reads return 0)
  - A write with hit and byteMask[3] = 1 pushes memWriteData[31:24], so SB/SW from the core send REGB[7:0].
  - If the FIFO is full before the edge, the push is dropped and ovf is set; a same-cycle pop does not rescue it.
- Offset 1, STATUS
  - Read fields: V[0] = full, V[1] = empty, V[2] = busy (state != IDLE), V[3] = ovf, V[8:4] = FIFO count, remaining bits 0.
  - A write with byteMask = 4'b1111 and byte-swapped value bit3 = 1 clears ovf (write-1-to-clear).
  - Clear and a new overflow in the same cycle: set wins.
- Offset 2, BAUDDIV
  - A write with byteMask = 4'b1111 loads div = byte-swapped memWriteData; a written value of 0 is stored as 1.
  - Reads return div.
  - div is sampled into frame_div when a frame starts, so a mid-frame write affects only later frames.
- Writes with a non-matching byteMask at any offset are ignored.
- FIFO
  - Circular buffer with read and write pointers that wrap modulo DEPTH, plus a count.
  - A push and a pop in the same cycle leave count unchanged.
- Transmit FSM: IDLE, START, DATA, STOP
  - A bit counter runs 0..frame_div-1; each bit lasts exactly frame_div cycles.
  - IDLE, FIFO non-empty at an edge: pop the head into the shift register, latch frame_div = div, go to START.
  - START: txd = 0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, txd = shift[0], shift right at each bit end; after bit 7, go to STOP.
  - STOP: txd = 1 for one bit period, then IDLE.
  - Back-to-back bytes therefore have exactly 1 idle cycle between the stop bit and the next start bit.
  - Latency: a push at edge N makes txd fall at edge N+1 when the FSM is IDLE.
- Reset (asynchronous)
  - FIFO emptied and pointers zeroed; ovf = 0; div = DEFAULT_DIV; state = IDLE.
  - txd = 1 and readData reflects the reset state.
  - Reset mid-frame aborts the frame and drives txd = 1 immediately.

Test Plan:
1. Reset, then read STATUS -> V = 32'h0000_0002 (empty); txd = 1; BAUDDIV reads 868.
2. Write BAUDDIV = 4, then SB 0x55 to TXDATA -> txd = 0 for 4 cycles starting the next edge, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop = 1, 40 cycles total; busy = 1 throughout.
3. DIV = 2; push 0xA5, 0x3C, 0x00, 0xFF, 0x11 while the first frame is in flight -> 0x11 is accepted only if a slot freed by a prior pop, otherwise dropped with ovf = 1; the serial stream matches the accepted bytes in order, with a 1-cycle gap between frames.
4. Fill FIFO to 4 with the FSM busy, push again -> count stays 4, ovf = 1; write STATUS with bit3 set -> ovf = 0.
5. DIV = 8, start a frame, write BAUDDIV = 2 mid-frame -> the current frame keeps 8-cycle bits; the next frame uses 2-cycle bits. Write BAUDDIV = 0 -> reads back 1.
6. Assert reset during DATA bit 3 -> txd = 1 immediately; STATUS = 0x2 afterwards; no partial frame resumes.
